// File: rtl/demux_router.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on the input and on each lane.
// Optional per-lane completed-transfer counters are built when DEMUX_CNT_EN is defined.
module demux_router #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [DW-1:0]    iData,
    input  logic [1:0]       iSel,
    output logic [3:0]       oValid,
    input  logic [3:0]       iReady,
    output logic [DW-1:0]    oData0,
    output logic [DW-1:0]    oData1,
    output logic [DW-1:0]    oData2,
    output logic [DW-1:0]    oData3,
`ifdef DEMUX_CNT_EN
    output logic [CNT_W-1:0] oCnt0,
    output logic [CNT_W-1:0] oCnt1,
    output logic [CNT_W-1:0] oCnt2,
    output logic [CNT_W-1:0] oCnt3,
`endif
    output logic             oBusy
);

    localparam int unsigned LANES = 4;

    logic [LANES-1:0] lane_v;
    logic [DW-1:0]    lane_d [LANES];
    logic             sel_full_c;
    logic             accept_c;

    // A lane is blocked only when it holds a word that its sink is not taking this cycle.
    always_comb begin
        sel_full_c = lane_v[iSel] & ~iReady[iSel];
        oReady     = iRst_n & ~sel_full_c;
        accept_c   = iValid & oReady;
    end

    // Fill has priority over drain, so a simultaneous drain and fill keeps the lane valid.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            lane_v <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lane_d[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (accept_c && (iSel == 2'(k))) begin
                    lane_v[k] <= 1'b1;
                    lane_d[k] <= iData;
                end else if (iReady[k]) begin
                    lane_v[k] <= 1'b0;
                end
            end
        end
    end

    assign oValid = lane_v;
    assign oData0 = lane_d[0];
    assign oData1 = lane_d[1];
    assign oData2 = lane_d[2];
    assign oData3 = lane_d[3];
    assign oBusy  = |lane_v;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] lane_cnt [LANES];

    // Counts words actually handed downstream; wraps naturally at all-ones.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                lane_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (lane_v[k] && iReady[k]) begin
                    lane_cnt[k] <= lane_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign oCnt0 = lane_cnt[0];
    assign oCnt1 = lane_cnt[1];
    assign oCnt2 = lane_cnt[2];
    assign oCnt3 = lane_cnt[3];
`endif

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-4 stream demultiplexer: routes one input word to one of four output lanes selected by a 2-bit lane code (00->lane0, 01->lane1, 10->lane2, 11->lane3).
- Counterpart of the team's 4:1 select/encoder logic: the fan-out end of the same 4-lane interface.
- Valid/ready handshake on the input and on every lane, with one register stage per lane. Backpressure on one lane never stalls traffic to the others.

Parameters:
- DW, 8, data width of input and each lane.
- CNT_W, 8, width of each per-lane transfer counter; used only with DEMUX_CNT_EN.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iValid  input  1  input word valid.
- oReady  output  1  demux can accept the word on iData toward lane iSel.
- iData  input  DW  input word.
- iSel  input  2  destination lane code; sampled only when iValid=1.
- oValid  output  4  per-lane valid; bit k belongs to lane k.
- iReady  input  4  per-lane downstream ready; bit k belongs to lane k.
- oData0..oData3  output  DW each  lane data registers.
- oBusy  output  1  OR of oValid.
- oCnt0..oCnt3  output  CNT_W each  per-lane completed-transfer counts; present only with DEMUX_CNT_EN.

Behaviour:
- Reset (iRst_n=0, asynchronous assert, synchronous release at next edge): oValid=4'b0000, oData0..3=0, oBusy=0, counters=0.
- oReady during reset is 0. Because oValid=0, iReady is don't-care during reset.
- Lane k state: valid bit V[k] drives oValid[k]; data register D[k] drives oDatak.
- oReady is combinational: oReady = ~V[iSel] | iReady[iSel]. It does not depend on iValid.
- Input accept: iValid & oReady at a rising edge.
- Lane k update at each edge, in priority order:
  - accept with iSel==k: V[k]<=1, D[k]<=iData.
  - else if iReady[k]: V[k]<=0, D[k] holds.
  - else: hold.
- Latency: a word accepted at edge N is visible on lane iSel after edge N, i.e. oValid[k]=1 in cycle N+1.
- Throughput: 1 word/cycle to the same lane when that lane's iReady=1 continuously; a simultaneous drain and fill keeps V[k]=1 and loads new data.
- Full lane (V[k]=1, iReady[k]=0) with iSel==k gives oReady=0. The input word stays pending; the upstream holds iValid, iData and iSel.
- Full lane k does not affect accepts to other lanes: an upstream that changes iSel to a free lane is accepted that cycle.
- Output stability: while oValid[k]=1 and iReady[k]=0, oDatak is held constant and oValid[k] stays 1.
- iValid=0: no lane is loaded and iSel may be X. Lanes still drain on their iReady.
- oBusy = |oValid, combinational from registers.
- Reset mid-operation clears all pending lane words; nothing is flushed downstream.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined:
  - Four CNT_W-bit counters, one per lane.
  - Counter k increments at each edge where oValid[k]&iReady[k] (a completed downstream transfer).
  - Counters wrap at all-ones to 0. Reset to 0 asynchronously.
  - Driven on oCnt0..oCnt3.
- Not defined: no counter registers and no oCnt ports. All other behaviour is identical.

Test Plan:
- Reset/idle: hold iRst_n=0 with random iValid/iSel -> oValid=0000, oData0..3=0, oBusy=0, oReady=0. Release with all iReady=1 -> oReady=1.
- Routing: iValid=1, all iReady=1, drive iSel=0,1,2,3 with iData=8'hA0,A1,A2,A3 on consecutive cycles -> one cycle later each, oValid pulses 0001,0010,0100,1000 with oData0..3=A0..A3.
- Backpressure isolation: iReady=4'b1110, send 8'h11 to lane0, then 8'h22 to lane0 -> oData0=11 is held and oReady=0 for the second word. Switch iSel=2 with 8'h33 -> accepted; oData2=33 next cycle. Raise iReady[0] -> 11 drains, 22 loads the following cycle.
- Simultaneous drain/fill: lane1 full with 8'h55, iReady[1]=1, iValid=1, iSel=1, iData=8'h66 -> oReady=1; next cycle oValid[1]=1, oData1=66, no bubble.
- Reset mid-operation: all lanes full with iReady=0000, pulse iRst_n=0 asynchronously between edges -> oValid=0000 immediately, before the next edge.
- DEMUX_CNT_EN (wrap): CNT_W=8, 256 transfers to lane3 with iReady[3]=1 -> oCnt3 counts 1..255 then 0; oCnt0..2 stay 0.
